cub_alu_arbiter: RTL and testbench

Shares one `cub_arithmetic` ALU between two requesters. Port 0 is the scalar/control issue path and port 1 is the cflow engine. The block arbitrates between them, registers and sequences each operation through the ALU (1 cycle for plain ops, 2 cycles for the truncating ops ADDT8/SUBT8/ADDT16/SUBT16), and returns tagged results on per-requester response channels with backpressure. It sits between the CU bank issue logic and the ALU instance and owns every ALU input.

---
 rtl/cub_alu_arbiter_if.sv | 30 +++
 rtl/cub_alu_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_cub_alu_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cub_alu_arbiter_if.sv
// Request/response channels between the two ALU requesters and cub_alu_arbiter.
// Port k of every packed vector lives at [k*W +: W].
interface cub_alu_arbiter_if #(
    parameter int ALU_OP_WIDTH = 7,
    parameter int TAG_W        = 4
);
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [2*ALU_OP_WIDTH-1:0] req_op;
    logic [63:0]               req_a;
    logic [63:0]               req_b;
    logic [9:0]                req_q;
    logic [2*TAG_W-1:0]        req_tag;
    logic [1:0]                rsp_valid;
    logic [1:0]                rsp_ready;
    logic [63:0]               rsp_data;
    logic [2*TAG_W-1:0]        rsp_tag;

    // Requester side
    modport master (
        output req_valid, req_op, req_a, req_b, req_q, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_q, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/cub_alu_arbiter.sv
// Shares one cub_arithmetic ALU between the scalar issue path (port 0) and the
// cflow engine (port 1). One op in flight per port; plain ops take one ALU
// cycle, truncating ops take two. Results are held in a per-port slot until
// the requester consumes them.
module cub_alu_arbiter #(
    parameter int                    ALU_OP_WIDTH = 7,
    parameter int                    TAG_W        = 4,
    parameter bit                    FIXED_PRIO   = 1'b0,
    // Truncating opcodes; values must match decode_param.v
    parameter logic [ALU_OP_WIDTH-1:0] ALU_ADDT8  = 7'd20,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_SUBT8  = 7'd21,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_ADDT16 = 7'd22,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_SUBT16 = 7'd23
) (
    input  logic                    clk,
    input  logic                    rst,
    cub_alu_arbiter_if.slave        bus,
    output logic                    alu_enable,
    output logic [ALU_OP_WIDTH-1:0] alu_operator,
    output logic [31:0]             alu_operand_a,
    output logic [31:0]             alu_operand_b,
    output logic [4:0]              alu_truncate_Q,
    output logic                    alu_cflow_mode,
    output logic [1:0]              alu_vect_mode,
    input  logic [31:0]             alu_result_i,
    input  logic                    alu_ready_i,
    output logic                    busy,
    output logic                    protocol_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        TRUNC = 2'd2
    } state_t;

    state_t                  state_reg;
    logic                    last_grant_reg;
    logic [ALU_OP_WIDTH-1:0] iss_op_reg;
    logic [31:0]             iss_a_reg;
    logic [31:0]             iss_b_reg;
    logic [4:0]              iss_q_reg;
    logic [TAG_W-1:0]        iss_tag_reg;
    logic                    iss_port_reg;
    logic                    alu_enable_reg;
    logic                    busy_reg;
    logic                    protocol_err_reg;

    wire  [1:0]              pending;
    wire  [1:0]              rsp_valid_w;
    wire  [63:0]             rsp_data_w;
    wire  [2*TAG_W-1:0]      rsp_tag_w;

    logic                    iss_trunc;
    logic                    issue_free;
    logic                    capture;
    logic [1:0]              elig;
    logic [1:0]              grant;
    logic                    grant_port;
    logic [1:0]              pop;
    logic [ALU_OP_WIDTH-1:0] sel_op;
    logic [31:0]             sel_a;
    logic [31:0]             sel_b;
    logic [4:0]              sel_q;
    logic [TAG_W-1:0]        sel_tag;

    function automatic logic is_trunc(input logic [ALU_OP_WIDTH-1:0] op);
        return (op == ALU_ADDT8) || (op == ALU_SUBT8) ||
               (op == ALU_ADDT16) || (op == ALU_SUBT16);
    endfunction

    // Arbitration: a new op may enter the ALU only when the current one frees it
    // at this edge; round-robin favours the port that was not granted last.
    always_comb begin
        iss_trunc  = is_trunc(iss_op_reg);
        issue_free = (state_reg == IDLE) || (state_reg == EXEC && !iss_trunc) ||
                     (state_reg == TRUNC);
        capture    = (state_reg == EXEC && !iss_trunc) || (state_reg == TRUNC);
        elig       = bus.req_valid & ~pending;
        grant      = 2'b00;
        if (issue_free && !rst) begin
            if (elig == 2'b11) begin
                grant = (FIXED_PRIO || last_grant_reg) ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
        grant_port = grant[1];
        pop        = rsp_valid_w & bus.rsp_ready;
        sel_op     = grant_port ? bus.req_op[ALU_OP_WIDTH +: ALU_OP_WIDTH] : bus.req_op[0 +: ALU_OP_WIDTH];
        sel_a      = grant_port ? bus.req_a[32 +: 32]   : bus.req_a[0 +: 32];
        sel_b      = grant_port ? bus.req_b[32 +: 32]   : bus.req_b[0 +: 32];
        sel_q      = grant_port ? bus.req_q[5 +: 5]     : bus.req_q[0 +: 5];
        sel_tag    = grant_port ? bus.req_tag[TAG_W +: TAG_W] : bus.req_tag[0 +: TAG_W];
    end

    // Sequencer: latches granted ops and walks them through EXEC (and TRUNC for
    // truncating ops); ALU enable and busy are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            last_grant_reg   <= 1'b1;
            iss_op_reg       <= '0;
            iss_a_reg        <= '0;
            iss_b_reg        <= '0;
            iss_q_reg        <= '0;
            iss_tag_reg      <= '0;
            iss_port_reg     <= 1'b0;
            alu_enable_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            if (|grant) begin
                iss_op_reg     <= sel_op;
                iss_a_reg      <= sel_a;
                iss_b_reg      <= sel_b;
                iss_q_reg      <= sel_q;
                iss_tag_reg    <= sel_tag;
                iss_port_reg   <= grant_port;
                last_grant_reg <= grant_port;
            end
            if (capture && !alu_ready_i) begin
                protocol_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        state_reg      <= EXEC;
                        alu_enable_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                EXEC: begin
                    if (iss_trunc) begin
                        state_reg      <= TRUNC;
                        alu_enable_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                    end else if (|grant) begin
                        state_reg      <= EXEC;
                        alu_enable_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end else begin
                        state_reg      <= IDLE;
                        alu_enable_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                    end
                end
                TRUNC: begin
                    if (|grant) begin
                        state_reg      <= EXEC;
                        alu_enable_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end else begin
                        state_reg      <= IDLE;
                        alu_enable_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    alu_enable_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic             pending_reg;
        logic             rsp_valid_reg;
        logic [31:0]      rsp_data_reg;
        logic [TAG_W-1:0] rsp_tag_reg;

        // Per-port slot: pending blocks a second grant until the result is popped,
        // so a valid slot is never overwritten.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pending_reg   <= 1'b0;
                rsp_valid_reg <= 1'b0;
                rsp_data_reg  <= '0;
                rsp_tag_reg   <= '0;
            end else begin
                if (grant[gi]) begin
                    pending_reg <= 1'b1;
                end else if (pop[gi]) begin
                    pending_reg <= 1'b0;
                end
                if (capture && (iss_port_reg == 1'(gi))) begin
                    rsp_valid_reg <= 1'b1;
                    rsp_data_reg  <= alu_result_i;
                    rsp_tag_reg   <= iss_tag_reg;
                end else if (pop[gi]) begin
                    rsp_valid_reg <= 1'b0;
                end
            end
        end

        assign pending[gi]                    = pending_reg;
        assign rsp_valid_w[gi]                = rsp_valid_reg;
        assign rsp_data_w[gi*32 +: 32]        = rsp_data_reg;
        assign rsp_tag_w[gi*TAG_W +: TAG_W]   = rsp_tag_reg;
    end

    assign bus.req_ready   = grant;
    assign bus.rsp_valid   = rsp_valid_w;
    assign bus.rsp_data    = rsp_data_w;
    assign bus.rsp_tag     = rsp_tag_w;

    // ALU inputs come straight from the issue registers so they hold between ops
    assign alu_enable      = alu_enable_reg;
    assign alu_operator    = iss_op_reg;
    assign alu_operand_a   = iss_a_reg;
    assign alu_operand_b   = iss_b_reg;
    assign alu_truncate_Q  = iss_q_reg;
    assign alu_cflow_mode  = 1'b0;
    assign alu_vect_mode   = 2'b00;
    assign busy            = busy_reg;
    assign protocol_err    = protocol_err_reg;

endmodule

// File: tb/tb_cub_alu_arbiter.sv
// Scoreboard bench for cub_alu_arbiter: a driver feeds per-port request queues,
// a negedge monitor pushes expected results on each request handshake and
// checks them (value, tag, latency, stability) as responses are consumed.
`timescale 1ns/1ps
module tb_cub_alu_arbiter;
    localparam int OPW = 7;
    localparam int TW  = 4;
    localparam logic [OPW-1:0] OP_ADD    = 7'd1;
    localparam logic [OPW-1:0] OP_SUB    = 7'd2;
    localparam logic [OPW-1:0] OP_AND    = 7'd3;
    localparam logic [OPW-1:0] OP_XOR    = 7'd4;
    localparam logic [OPW-1:0] OP_ADDT8  = 7'd20;
    localparam logic [OPW-1:0] OP_SUBT8  = 7'd21;
    localparam logic [OPW-1:0] OP_ADDT16 = 7'd22;
    localparam logic [OPW-1:0] OP_SUBT16 = 7'd23;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [4:0]     q;
        logic [TW-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        int            due;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           alu_enable;
    logic [OPW-1:0] alu_operator;
    logic [31:0]    alu_operand_a;
    logic [31:0]    alu_operand_b;
    logic [4:0]     alu_truncate_Q;
    logic           alu_cflow_mode;
    logic [1:0]     alu_vect_mode;
    logic [31:0]    alu_result_i;
    logic           alu_ready_i;
    logic           busy;
    logic           protocol_err;

    cub_alu_arbiter_if #(.ALU_OP_WIDTH(OPW), .TAG_W(TW)) bus ();

    cub_alu_arbiter #(
        .ALU_OP_WIDTH(OPW), .TAG_W(TW), .FIXED_PRIO(1'b0),
        .ALU_ADDT8(OP_ADDT8), .ALU_SUBT8(OP_SUBT8),
        .ALU_ADDT16(OP_ADDT16), .ALU_SUBT16(OP_SUBT16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_enable(alu_enable), .alu_operator(alu_operator),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_truncate_Q(alu_truncate_Q), .alu_cflow_mode(alu_cflow_mode),
        .alu_vect_mode(alu_vect_mode), .alu_result_i(alu_result_i),
        .alu_ready_i(alu_ready_i), .busy(busy), .protocol_err(protocol_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          en_cnt   = 0;
    int          grant_cnt [2];
    int          last_grant_cyc [2];
    logic [31:0] last_pop_data [2];
    logic [TW-1:0] last_pop_tag [2];
    req_t        stim_q [2][$];
    exp_t        exp_q  [2][$];
    int          grant_log [$];
    bit          alu_ready_force;
    bit [1:0]    hold_rdy;
    bit          rand_rdy;

    function automatic bit is_trunc(input logic [OPW-1:0] op);
        return op == OP_ADDT8 || op == OP_SUBT8 || op == OP_ADDT16 || op == OP_SUBT16;
    endfunction

    // What the ALU is supposed to compute: plain wrap-around logic/arith, or
    // signed add/sub, arithmetic shift by Q, then saturate to 8 or 16 bits.
    function automatic logic [31:0] ref_alu(input logic [OPW-1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] q);
        longint s;
        longint lim;
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_XOR: return a ^ b;
            default: begin
                lim = (op == OP_ADDT8 || op == OP_SUBT8) ? 127 : 32767;
                if (op == OP_ADDT8 || op == OP_ADDT16)
                    s = longint'($signed(a)) + longint'($signed(b));
                else
                    s = longint'($signed(a)) - longint'($signed(b));
                s = s >>> q;
                if (s > lim) s = lim;
                else if (s < -lim - 1) s = -lim - 1;
                return s[31:0];
            end
        endcase
    endfunction

    function automatic req_t mk(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] q, input logic [TW-1:0] tag);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.q = q; r.tag = tag;
        return r;
    endfunction

    function automatic req_t rand_req(input bit plain_only);
        logic [OPW-1:0] op;
        case ($urandom_range(0, plain_only ? 3 : 7))
            0: op = OP_ADD;    1: op = OP_SUB;    2: op = OP_AND;   3: op = OP_XOR;
            4: op = OP_ADDT8;  5: op = OP_SUBT8;  6: op = OP_ADDT16;
            default: op = OP_SUBT16;
        endcase
        return mk(op, $urandom, $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Behavioural ALU: plain result is combinational while enabled; a truncating
    // result only appears the cycle after enable (poison value while enabled).
    logic [31:0] alu_hold;
    always_ff @(posedge clk)
        if (alu_enable) alu_hold <= ref_alu(alu_operator, alu_operand_a, alu_operand_b, alu_truncate_Q);

    always_comb begin
        alu_result_i = alu_hold;
        if (alu_enable)
            alu_result_i = is_trunc(alu_operator) ? 32'hDEAD_BEEF
                         : ref_alu(alu_operator, alu_operand_a, alu_operand_b, alu_truncate_Q);
    end
    assign alu_ready_i = alu_ready_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Driver: presents the head of each port queue until the monitor sees it taken
    initial begin
        req_t r;
        bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_q = '0; bus.req_tag = '0; bus.rsp_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (stim_q[k].size() != 0 && !rst) begin
                    r = stim_q[k][0];
                    bus.req_valid[k] = 1'b1;
                    bus.req_op[k*OPW +: OPW] = r.op;
                    bus.req_a[k*32 +: 32]    = r.a;
                    bus.req_b[k*32 +: 32]    = r.b;
                    bus.req_q[k*5 +: 5]      = r.q;
                    bus.req_tag[k*TW +: TW]  = r.tag;
                end else begin
                    bus.req_valid[k] = 1'b0;
                end
                bus.rsp_ready[k] = hold_rdy[k] ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        req_t        r;
        exp_t        e;
        bit          prev_rv [2];
        bit          prev_pop [2];
        logic [31:0] prev_data [2];
        logic [TW-1:0] prev_tag [2];
        bit          prev_en;
        logic [OPW-1:0] prev_op;
        logic [4:0]  prev_q;
        prev_en = 0; prev_op = '0; prev_q = '0;
        for (int k = 0; k < 2; k++) begin
            prev_rv[k] = 0; prev_pop[k] = 0; prev_data[k] = '0; prev_tag[k] = '0;
            grant_cnt[k] = 0; last_grant_cyc[k] = 0; last_pop_data[k] = '0; last_pop_tag[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q[0].delete();
                exp_q[1].delete();
                prev_en = 0;
                for (int k = 0; k < 2; k++) begin
                    prev_rv[k] = 0; prev_pop[k] = 0;
                end
            end else begin
                if (alu_enable) en_cnt++;
                if (prev_en && !alu_enable && busy) begin
                    check("trunc_operator_held", alu_operator, prev_op);
                    check("trunc_Q_held", alu_truncate_Q, prev_q);
                end
                prev_en = alu_enable; prev_op = alu_operator; prev_q = alu_truncate_Q;
                for (int k = 0; k < 2; k++) begin
                    if (bus.req_valid[k] && bus.req_ready[k] && stim_q[k].size() != 0) begin
                        r = stim_q[k].pop_front();
                        e.data = ref_alu(r.op, r.a, r.b, r.q);
                        e.tag  = r.tag;
                        e.due  = cyc + (is_trunc(r.op) ? 3 : 2);
                        exp_q[k].push_back(e);
                        grant_log.push_back(k);
                        grant_cnt[k]++;
                        last_grant_cyc[k] = cyc;
                    end
                    if (bus.rsp_valid[k] && !prev_rv[k]) begin
                        if (exp_q[k].size() == 0)
                            check($sformatf("rsp_without_request_p%0d", k), 1, 0);
                        else
                            check($sformatf("latency_p%0d", k), cyc, exp_q[k][0].due);
                    end
                    if (bus.rsp_valid[k] && prev_rv[k] && !prev_pop[k]) begin
                        check($sformatf("rsp_data_stable_p%0d", k), bus.rsp_data[k*32 +: 32], prev_data[k]);
                        check($sformatf("rsp_tag_stable_p%0d", k), bus.rsp_tag[k*TW +: TW], prev_tag[k]);
                    end
                    prev_pop[k] = bus.rsp_valid[k] && bus.rsp_ready[k];
                    if (prev_pop[k]) begin
                        if (exp_q[k].size() == 0) begin
                            check($sformatf("pop_without_request_p%0d", k), 1, 0);
                        end else begin
                            e = exp_q[k].pop_front();
                            check($sformatf("rsp_data_p%0d", k), bus.rsp_data[k*32 +: 32], e.data);
                            check($sformatf("rsp_tag_p%0d", k), bus.rsp_tag[k*TW +: TW], e.tag);
                            last_pop_data[k] = bus.rsp_data[k*32 +: 32];
                            last_pop_tag[k]  = bus.rsp_tag[k*TW +: TW];
                        end
                    end
                    prev_rv[k]   = bus.rsp_valid[k];
                    prev_data[k] = bus.rsp_data[k*32 +: 32];
                    prev_tag[k]  = bus.rsp_tag[k*TW +: TW];
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 || busy) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: timeout after %0d cycles with work outstanding", name, budget);
                return;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int g1;
        int n;
        logic [31:0] snap;
        rst = 1'b1; alu_ready_force = 1'b1; hold_rdy = '0; rand_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_rsp_tag", bus.rsp_tag, 0);
        check("reset_alu_enable", alu_enable, 0);
        check("reset_alu_operator", alu_operator, 0);
        check("reset_alu_operand_a", alu_operand_a, 0);
        check("reset_alu_operand_b", alu_operand_b, 0);
        check("reset_alu_Q", alu_truncate_Q, 0);
        check("reset_busy", busy, 0);
        check("reset_protocol_err", protocol_err, 0);
        check("tied_cflow_mode", alu_cflow_mode, 0);
        check("tied_vect_mode", alu_vect_mode, 0);

        // Both ports always valid with plain ops: grants alternate from port 0
        grant_log.delete();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 2; k++) stim_q[k].push_back(rand_req(1'b1));
        wait_idle("alternate", 200);
        check("alt_grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("alt_grant_%0d", i), grant_log[i], i % 2);

        // Port 0 ADD 5+7
        e0 = en_cnt;
        stim_q[0].push_back(mk(OP_ADD, 32'd5, 32'd7, 5'd0, 4'h3));
        wait_idle("add", 50);
        check("add_data", last_pop_data[0], 32'd12);
        check("add_tag", last_pop_tag[0], 4'h3);
        check("add_enable_cycles", en_cnt - e0, 1);

        // Port 1 ADDT8 saturating
        e0 = en_cnt;
        stim_q[1].push_back(mk(OP_ADDT8, 32'h100, 32'h80, 5'd1, 4'hA));
        wait_idle("addt8", 50);
        check("addt8_data", last_pop_data[1], 32'h0000_007F);
        check("addt8_tag", last_pop_tag[1], 4'hA);
        check("addt8_enable_cycles", en_cnt - e0, 1);

        // Port 0 trunc op, port 1 plain op arrives behind it: granted in TRUNC
        stim_q[0].push_back(mk(OP_SUBT16, 32'h0001_2345, 32'h0000_1000, 5'd2, 4'h5));
        @(negedge clk);
        stim_q[1].push_back(mk(OP_ADD, 32'h11, 32'h22, 5'd0, 4'h6));
        wait_idle("trunc_then_plain", 50);
        check("trunc_then_plain_gap", last_grant_cyc[1] - last_grant_cyc[0], 2);
        check("trunc_then_plain_p1_data", last_pop_data[1], 32'h33);

        // Backpressure on port 0 while port 1 keeps flowing
        hold_rdy[0] = 1'b1;
        for (int i = 0; i < 3; i++) stim_q[0].push_back(rand_req(1'b0));
        for (int i = 0; i < 6; i++) stim_q[1].push_back(rand_req(1'b1));
        n = 0;
        while (!bus.rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid0_seen", bus.rsp_valid[0], 1);
        snap = bus.rsp_data[31:0];
        g1 = grant_cnt[1];
        repeat (10) begin
            @(negedge clk);
            check("bp_req_ready0_low", bus.req_ready[0], 0);
            check("bp_rsp_data0_stable", bus.rsp_data[31:0], snap);
        end
        check("bp_port1_progress", (grant_cnt[1] - g1) >= 2, 1);
        hold_rdy[0] = 1'b0;
        wait_idle("backpressure", 200);

        // Randomised traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 3) != 0) stim_q[k].push_back(rand_req(1'b0));
            @(negedge clk);
        end
        wait_idle("random", 4000);
        rand_rdy = 1'b0;

        // Reset while a truncating op sits in TRUNC: op is dropped
        stim_q[1].push_back(mk(OP_ADDT16, $urandom, $urandom, 5'd3, 4'h9));
        n = 0;
        while (!(busy && !alu_enable) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_trunc", busy && !alu_enable, 1);
        #2 rst = 1'b1;
        stim_q[0].delete();
        stim_q[1].delete();
        #1;
        check("rst_async_rsp_valid", bus.rsp_valid, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_alu_enable", alu_enable, 0);
        check("rst_async_alu_operator", alu_operator, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_no_rsp", bus.rsp_valid, 0);
            check("post_rst_not_busy", busy, 0);
        end

        // ALU not ready at capture: sticky protocol error
        check("perr_clear_before", protocol_err, 0);
        alu_ready_force = 1'b0;
        stim_q[0].push_back(mk(OP_XOR, 32'hF0F0_0000, 32'h0F0F_1234, 5'd0, 4'h2));
        wait_idle("perr_op", 50);
        alu_ready_force = 1'b1;
        check("perr_set", protocol_err, 1);
        stim_q[1].push_back(rand_req(1'b0));
        wait_idle("perr_sticky_op", 50);
        check("perr_sticky", protocol_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("perr_cleared_by_rst", protocol_err, 0);

        check("enable_once_per_grant", en_cnt, grant_cnt[0] + grant_cnt[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
